mm_arbiter: RTL and testbench

MM_ARBITER -- requirements
Module: mm_arbiter

---
 rtl/mm_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mm_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mm_arbiter.sv
// Two-port arbiter (256-bit line port, 32-bit bypass port) onto one memory port.
// One transaction in flight: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
module mm_arbiter #(
  parameter int ADDR_BITS = 15,
  parameter int TIMEOUT   = 15
) (
  input  logic         clk,
  input  logic         reset,
  // line port
  input  logic         l_req,
  input  logic         l_we,
  input  logic [31:0]  l_addr,
  input  logic [255:0] l_wd,
  output logic         l_gnt,
  output logic         l_done,
  output logic         l_err,
  output logic [255:0] l_rd,
  // bypass port
  input  logic         b_req,
  input  logic         b_we,
  input  logic [31:0]  b_addr,
  input  logic [3:0]   b_be,
  input  logic [31:0]  b_wd,
  output logic         b_gnt,
  output logic         b_done,
  output logic         b_err,
  output logic [31:0]  b_rd,
  // memory port
  output logic [31:0]  mm_a,
  output logic [3:0]   mm_be,
  output logic         mm_write,
  output logic         mm_read,
  output logic         mm_bypass,
  output logic [255:0] mm_wd,
  input  logic [255:0] mm_rd,
  input  logic         mm_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t         r_state;
  state_t         w_state_next;

  logic           r_port;       // 1 = bypass owns the transaction
  logic           r_we;
  logic [3:0]     r_be;
  logic           r_err;
  logic [3:0]     r_cnt;
  logic           r_last_byp;
  logic [255:0]   r_line_rd;
  logic [31:0]    r_byp_rd;
  logic [31:0]    r_mm_a;
  logic [255:0]   r_mm_wd;

  logic           w_l_addr_err;
  logic           w_b_addr_err;
  logic           w_l_win;
  logic           w_b_win;
  logic           w_capture;
  logic           w_sel_err;
  logic           w_timeout;

  generate
    if (ADDR_BITS < 32) begin : g_addr_chk
      assign w_l_addr_err = |l_addr[31:ADDR_BITS];
      assign w_b_addr_err = |b_addr[31:ADDR_BITS];
    end else begin : g_addr_full
      assign w_l_addr_err = 1'b0;
      assign w_b_addr_err = 1'b0;
    end
  endgenerate

  // On a tie the port that did not win last time gets the grant.
  assign w_l_win   = (r_state == S_IDLE) && l_req && (!b_req || r_last_byp);
  assign w_b_win   = (r_state == S_IDLE) && b_req && !w_l_win;
  assign w_capture = w_l_win || w_b_win;
  assign w_sel_err = w_l_win ? w_l_addr_err : w_b_addr_err;
  assign w_timeout = (r_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    l_gnt        = 1'b0;
    b_gnt        = 1'b0;
    l_done       = 1'b0;
    l_err        = 1'b0;
    l_rd         = '0;
    b_done       = 1'b0;
    b_err        = 1'b0;
    b_rd         = '0;
    mm_read      = 1'b0;
    mm_write     = 1'b0;
    mm_be        = 4'h0;
    mm_bypass    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Grants are masked while reset is held so every output reads zero.
        l_gnt = w_l_win && reset;
        b_gnt = w_b_win && reset;
        if (w_capture) begin
          w_state_next = w_sel_err ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mm_read      = !r_we;
        mm_write     = r_we;
        mm_be        = r_be;
        mm_bypass    = r_port;
        w_state_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mm_valid || w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (r_port) begin
          b_done = 1'b1;
          b_err  = r_err;
          b_rd   = r_byp_rd;
        end else begin
          l_done = 1'b1;
          l_err  = r_err;
          l_rd   = r_line_rd;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_err      <= 1'b0;
      r_cnt      <= 4'h0;
      r_last_byp <= 1'b1;
      r_line_rd  <= '0;
      r_byp_rd   <= '0;
      r_mm_a     <= '0;
      r_mm_wd    <= '0;
    end else if (w_capture) begin
      r_port     <= w_b_win;
      r_we       <= w_b_win ? b_we : l_we;
      r_be       <= w_b_win ? b_be : 4'hF;
      r_err      <= w_sel_err;
      r_cnt      <= 4'h0;
      r_last_byp <= w_b_win;
      r_line_rd  <= '0;
      r_byp_rd   <= '0;
      // Memory address/data only move for transactions that will be issued.
      if (!w_sel_err) begin
        r_mm_a  <= w_b_win ? b_addr : l_addr;
        r_mm_wd <= w_b_win ? {224'b0, b_wd} : l_wd;
      end
    end else if (r_state == S_WAIT) begin
      if (mm_valid) begin
        if (r_port) begin
          r_byp_rd <= mm_rd[31:0];
        end else begin
          r_line_rd <= mm_rd;
        end
      end else if (w_timeout) begin
        r_err     <= 1'b1;
        r_line_rd <= '0;
        r_byp_rd  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'h1;
      end
    end
  end

  assign mm_a  = r_mm_a;
  assign mm_wd = r_mm_wd;

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter: inputs change at posedge+1, outputs are checked at posedge+2.
module tb_mm_arbiter;

  localparam int TB_ADDR_BITS = 15;
  localparam int TB_TIMEOUT   = 15;

  logic         clk;
  logic         reset;
  logic         l_req, l_we;
  logic [31:0]  l_addr;
  logic [255:0] l_wd;
  logic         l_gnt, l_done, l_err;
  logic [255:0] l_rd;
  logic         b_req, b_we;
  logic [31:0]  b_addr;
  logic [3:0]   b_be;
  logic [31:0]  b_wd;
  logic         b_gnt, b_done, b_err;
  logic [31:0]  b_rd;
  logic [31:0]  mm_a;
  logic [3:0]   mm_be;
  logic         mm_write, mm_read, mm_bypass;
  logic [255:0] mm_wd;
  logic [255:0] mm_rd;
  logic         mm_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] pat_p  = 256'h88887777_66665555_44443333_22221111_FEDCBA98_76543210_0F0F0F0F_A5A5C3C3;
  logic [255:0] line_w = 256'h01234567_89ABCDEF_DEAD0001_BEEF0002_CAFE0003_F00D0004_12345678_9ABCDEF0;

  mm_arbiter #(
    .ADDR_BITS(TB_ADDR_BITS),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wd     (l_wd),
    .l_gnt    (l_gnt),
    .l_done   (l_done),
    .l_err    (l_err),
    .l_rd     (l_rd),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_be     (b_be),
    .b_wd     (b_wd),
    .b_gnt    (b_gnt),
    .b_done   (b_done),
    .b_err    (b_err),
    .b_rd     (b_rd),
    .mm_a     (mm_a),
    .mm_be    (mm_be),
    .mm_write (mm_write),
    .mm_read  (mm_read),
    .mm_bypass(mm_bypass),
    .mm_wd    (mm_wd),
    .mm_rd    (mm_rd),
    .mm_valid (mm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waits;
    logic exp_l, exp_b;

    reset = 1'b0;
    l_req = 0; l_we = 0; l_addr = '0; l_wd = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_be = '0; b_wd = '0;
    mm_rd = '0; mm_valid = 0;

    // Held in reset: requests must not be granted, everything reads zero.
    repeat (3) @(posedge clk);
    #1; l_req = 1; b_req = 1; #1;
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_b_gnt", b_gnt, 1'b0);
    chk("rst_mm_a", mm_a, 32'h0);
    chk("rst_mm_wd", mm_wd, 256'h0);
    chk("rst_done", {l_done, b_done, mm_read, mm_write}, 4'h0);
    l_req = 0; b_req = 0;

    // Bypass write, granted in the first cycle after reset release.
    cyc(); reset = 1'b1;
    b_req = 1; b_we = 1; b_addr = 32'h24; b_be = 4'b0011; b_wd = 32'hDEADBEEF; #1;
    chk("bw_b_gnt", b_gnt, 1'b1);
    chk("bw_l_gnt", l_gnt, 1'b0);
    cyc(); b_req = 0; b_addr = 32'h0; b_be = 4'h0; b_wd = 32'h0; #1;
    chk("bw_mm_write", mm_write, 1'b1);
    chk("bw_mm_read", mm_read, 1'b0);
    chk("bw_mm_bypass", mm_bypass, 1'b1);
    chk("bw_mm_a", mm_a, 32'h24);
    chk("bw_mm_be", mm_be, 4'b0011);
    chk("bw_mm_wd", mm_wd, {224'b0, 32'hDEADBEEF});
    chk("bw_b_done_early", b_done, 1'b0);
    cyc(); l_req = 1; l_we = 0; l_addr = 32'h40; #1;
    chk("bw_b_done", b_done, 1'b1);
    chk("bw_b_err", b_err, 1'b0);
    chk("bw_mm_write_off", mm_write, 1'b0);
    chk("bw_mm_a_hold", mm_a, 32'h24);
    chk("done_no_gnt", l_gnt, 1'b0);

    // Line read, memory answers one cycle after mm_read.
    cyc(); #1;
    chk("lr_l_gnt", l_gnt, 1'b1);
    chk("lr_b_done_off", b_done, 1'b0);
    cyc(); l_req = 0; l_addr = 32'h0; #1;
    chk("lr_mm_read", mm_read, 1'b1);
    chk("lr_mm_bypass", mm_bypass, 1'b0);
    chk("lr_mm_a", mm_a, 32'h40);
    chk("lr_mm_be", mm_be, 4'hF);
    cyc(); mm_valid = 1; mm_rd = pat_p; #1;
    chk("lr_mm_read_once", mm_read, 1'b0);
    chk("lr_l_done_early", l_done, 1'b0);
    cyc(); mm_valid = 0; mm_rd = '0; #1;
    chk("lr_l_done", l_done, 1'b1);
    chk("lr_l_err", l_err, 1'b0);
    chk("lr_l_rd", l_rd, pat_p);

    // Bypass address error.
    cyc(); b_req = 1; b_we = 0; b_addr = 32'h0000_8000; #1;
    chk("ae_b_gnt", b_gnt, 1'b1);
    chk("ae_l_done_off", l_done, 1'b0);
    cyc(); b_req = 0; b_addr = 32'h0; #1;
    chk("ae_b_done", b_done, 1'b1);
    chk("ae_b_err", b_err, 1'b1);
    chk("ae_no_issue", {mm_read, mm_write}, 2'b00);
    chk("ae_mm_a_hold", mm_a, 32'h40);
    cyc(); #1;
    chk("ae_b_done_off", b_done, 1'b0);

    // Both ports held: bypass won last, so line first, then alternate.
    cyc();
    l_req = 1; l_we = 1; l_addr = 32'h100; l_wd = line_w;
    b_req = 1; b_we = 1; b_addr = 32'h104; b_be = 4'hC; b_wd = 32'h55;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      #1;
      exp_l = (c % 6 == 0);
      exp_b = (c % 6 == 3);
      chk($sformatf("tie_l_gnt_c%0d", c), l_gnt, exp_l);
      chk($sformatf("tie_b_gnt_c%0d", c), b_gnt, exp_b);
      if (c == 1) begin
        chk("tie_l_mm_wd", mm_wd, line_w);
        chk("tie_l_mm_be", mm_be, 4'hF);
        chk("tie_l_mm_write", mm_write, 1'b1);
      end
      if (c == 4) begin
        chk("tie_b_mm_wd", mm_wd, {224'b0, 32'h55});
        chk("tie_b_mm_be", mm_be, 4'hC);
        chk("tie_b_mm_bypass", mm_bypass, 1'b1);
      end
    end
    cyc(); l_req = 0; b_req = 0; #1;
    chk("tie_end_gnt", {l_gnt, b_gnt}, 2'b00);

    // Line read timeout; a stray mm_valid during ISSUE must be ignored.
    cyc(); l_req = 1; l_we = 0; l_addr = 32'h80; #1;
    chk("to_l_gnt", l_gnt, 1'b1);
    cyc(); l_req = 0; mm_valid = 1; mm_rd = pat_p; #1;
    chk("to_mm_read", mm_read, 1'b1);
    cyc(); mm_valid = 0; mm_rd = '0; #1;
    waits = 0;
    while (l_done !== 1'b1 && waits < 40) begin
      cyc(); #1;
      waits++;
    end
    chk("to_wait_cycles", waits, TB_TIMEOUT);
    chk("to_l_done", l_done, 1'b1);
    chk("to_l_err", l_err, 1'b1);
    chk("to_l_rd", l_rd, 256'h0);

    // Reset asserted during WAIT.
    cyc(); l_req = 1; l_we = 0; l_addr = 32'h40; #1;
    chk("rw_l_gnt", l_gnt, 1'b1);
    cyc(); l_req = 0; #1;
    chk("rw_mm_read", mm_read, 1'b1);
    cyc(); reset = 1'b0; #1;
    chk("rw_mm_a", mm_a, 32'h0);
    chk("rw_mm_wd", mm_wd, 256'h0);
    chk("rw_ctrl", {mm_read, mm_write, mm_bypass, mm_be}, 7'h0);
    chk("rw_done", {l_done, l_err, b_done, b_err}, 4'h0);
    mm_valid = 1; mm_rd = pat_p;
    cyc(); mm_valid = 0; mm_rd = '0; #1;
    chk("rw_l_done_held", l_done, 1'b0);
    reset = 1'b1;
    l_req = 1; l_we = 1; l_addr = 32'h100; l_wd = line_w;
    b_req = 1; b_we = 1; b_addr = 32'h104; #1;
    chk("rw_no_done", l_done, 1'b0);
    chk("rw_new_l_gnt", l_gnt, 1'b1);
    chk("rw_new_b_gnt", b_gnt, 1'b0);
    cyc(); l_req = 0; b_req = 0; #1;
    chk("rw_new_mm_write", mm_write, 1'b1);
    chk("rw_new_mm_a", mm_a, 32'h100);
    cyc(); #1;
    chk("rw_new_l_done", l_done, 1'b1);
    chk("rw_new_l_err", l_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
